// File: rtl/ifu_mq_pkg.sv
// rtl/ifu_mq_pkg.sv - shared types, defaults and helpers for the ifu_mq fetch unit
package ifu_mq_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;
    localparam int          MAX_FETCH_WIDTH  = 4;

    typedef enum logic [1:0] {
        EXC_ADEF = 2'd0,
        EXC_TLBR = 2'd1,
        EXC_PIF  = 2'd2,
        EXC_PPI  = 2'd3
    } exception_t;

    typedef struct packed {
        logic [MAX_FETCH_WIDTH-1:0][31:0] pc;
        logic [MAX_FETCH_WIDTH-1:0][31:0] inst;
        logic [2:0]                       size;
    } fetch_pkt_t;

    // Word position of addr inside its aligned fetch block.
    function automatic int word_off(input logic [31:0] addr, input int fetch_width);
        return int'((addr >> 2) & 32'(fetch_width - 1));
    endfunction

endpackage

// File: rtl/ifu_mq_if.sv
// rtl/ifu_mq_if.sv - I-side MMU request/response port between ifu_mq and the MMU
interface ifu_mq_if #(
    parameter int FETCH_WIDTH = 2
);
    localparam int SW = $clog2(FETCH_WIDTH + 1);

    logic                         valid;
    logic [31:0]                  addr;
    logic [SW-1:0]                size;
    logic                         addr_ok;
    logic                         data_ok;
    logic [FETCH_WIDTH-1:0][31:0] rdata;
    logic                         tlbr;
    logic                         pif;
    logic                         ppi;

    modport master (
        output valid, addr, size,
        input  addr_ok, data_ok, rdata, tlbr, pif, ppi
    );

    modport slave (
        input  valid, addr, size,
        output addr_ok, data_ok, rdata, tlbr, pif, ppi
    );

endinterface

// File: rtl/ifu_pc_fifo.sv
// rtl/ifu_pc_fifo.sv - synchronous FIFO of in-flight fetch PCs with push, pop, clear and occupancy
module ifu_pc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != OW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + OW'(do_push) - OW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_mq.sv
// rtl/ifu_mq.sv - multi-outstanding instruction fetch unit with kill-counter squash
// Optional IFU_PERF_CNT_EN adds saturating perf counter output ports.
module ifu_mq
    import ifu_mq_pkg::*;
#(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ibuf_ready,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]    ibuf_input_size,
    output logic [FETCH_WIDTH-1:0][31:0]        pc,
    output logic [FETCH_WIDTH-1:0][31:0]        inst,
    output logic                                have_exception,
    output exception_t                          exception_type,
    input  logic                                branch_mistaken,
    input  logic [31:0]                         correct_target,
    input  logic                                rewind,
    input  logic [31:0]                         rewind_target,
    input  logic                                raise_exception,
    input  logic [31:0]                         exception_target,
    ifu_mq_if.master                            mmu_i
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_fetch_pkts,
    output logic [31:0]                         perf_killed_resps,
    output logic [31:0]                         perf_stall_cycles
`endif
);
    localparam int          SW       = $clog2(FETCH_WIDTH + 1);
    localparam int          OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] BLK_MASK = 32'(4 * FETCH_WIDTH - 1);

    logic [31:0]                  fetch_pc;
    logic [31:0]                  fifo_head;
    logic [OW-1:0]                fifo_occ;
    logic [OW-1:0]                kill_cnt;
    logic                         halted;
    logic                         fault_any;
    logic                         room;
    logic                         accept;
    logic                         redirect;
    logic                         live_resp;
    logic                         fault_report;
    logic [31:0]                  redirect_target;
    exception_t                   fault_type;
    int                           head_off;
    logic [FETCH_WIDTH-1:0][31:0] rdata_aligned;

    always_comb begin
        fault_type = EXC_PPI;
        if (fetch_pc[1:0] != 2'b00) fault_type = EXC_ADEF;
        else if (mmu_i.tlbr)        fault_type = EXC_TLBR;
        else if (mmu_i.pif)         fault_type = EXC_PIF;
    end

    always_comb begin
        redirect_target = correct_target;
        if (raise_exception)  redirect_target = exception_target;
        else if (rewind)      redirect_target = rewind_target;
    end

    assign fault_any = (fetch_pc[1:0] != 2'b00) || mmu_i.tlbr || mmu_i.pif || mmu_i.ppi;
    assign room      = (int'(fifo_occ) + int'(kill_cnt)) < MAX_OUTSTANDING;
    assign redirect  = raise_exception || rewind || branch_mistaken;

    assign mmu_i.valid = !reset && !halted && !fault_any && ibuf_ready && (room || mmu_i.data_ok);
    assign mmu_i.addr  = fetch_pc;
    assign mmu_i.size  = SW'(FETCH_WIDTH - word_off(fetch_pc, FETCH_WIDTH));
    assign accept      = mmu_i.valid && mmu_i.addr_ok;

    // Faults wait for an empty pipe so the exception lands behind every older packet.
    assign live_resp    = !reset && mmu_i.data_ok && (kill_cnt == '0) && (fifo_occ != '0);
    assign fault_report = !reset && fault_any && (fifo_occ == '0) && (kill_cnt == '0)
                          && !halted && !redirect;

    assign head_off      = word_off(fifo_head, FETCH_WIDTH);
    assign rdata_aligned = mmu_i.rdata >> (32 * head_off);

    always_comb begin
        ibuf_input_size = '0;
        pc              = '0;
        inst            = '0;
        have_exception  = 1'b0;
        exception_type  = fault_type;
        if (live_resp && !redirect) begin
            ibuf_input_size = SW'(FETCH_WIDTH - head_off);
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k < FETCH_WIDTH - head_off) begin
                    pc[k]   = fifo_head + 32'(4 * k);
                    inst[k] = rdata_aligned[k];
                end
            end
        end else if (fault_report) begin
            have_exception  = 1'b1;
            ibuf_input_size = SW'(1);
            pc[0]           = fetch_pc;
        end
    end

    ifu_pc_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !redirect),
        .pop   (live_resp && !redirect),
        .clear (redirect),
        .din   (fetch_pc),
        .head  (fifo_head),
        .occ   (fifo_occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            kill_cnt <= '0;
            halted   <= 1'b0;
        end else if (redirect) begin
            // Everything still owed by the MMU, including this cycle's accept, becomes stale.
            fetch_pc <= redirect_target;
            kill_cnt <= OW'(int'(kill_cnt) + int'(fifo_occ) + int'(accept)
                            - int'(mmu_i.data_ok && ((kill_cnt != '0) || (fifo_occ != '0))));
            halted   <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= (fetch_pc & ~BLK_MASK) + 32'(4 * FETCH_WIDTH);
            end
            if (mmu_i.data_ok && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - OW'(1);
            end
            if (fault_report) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_pkts   <= '0;
            perf_killed_resps <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (live_resp && !redirect && (perf_fetch_pkts != '1)) begin
                perf_fetch_pkts <= perf_fetch_pkts + 32'd1;
            end
            if (mmu_i.data_ok && ((kill_cnt != '0) || redirect) && (perf_killed_resps != '1)) begin
                perf_killed_resps <= perf_killed_resps + 32'd1;
            end
            if (!ibuf_ready && !halted && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_mq.sv
// tb/tb_ifu_mq.sv - directed self-checking bench for ifu_mq with a one-cycle in-order MMU model
module tb_ifu_mq;
    import ifu_mq_pkg::*;

    localparam int          FW  = 2;
    localparam logic [31:0] KEY = 32'h5a000000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ibuf_ready;
    logic [1:0]           ibuf_input_size;
    logic [FW-1:0][31:0]  pc;
    logic [FW-1:0][31:0]  inst;
    logic                 have_exception;
    exception_t           exception_type;
    logic                 branch_mistaken;
    logic [31:0]          correct_target;
    logic                 rewind;
    logic [31:0]          rewind_target;
    logic                 raise_exception;
    logic [31:0]          exception_target;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]          perf_fetch_pkts;
    logic [31:0]          perf_killed_resps;
    logic [31:0]          perf_stall_cycles;
`endif

    ifu_mq_if #(.FETCH_WIDTH(FW)) mmu_i ();

    logic        resp_en;
    logic [31:0] pend [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ifu_mq #(
        .FETCH_WIDTH     (FW),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h1c000000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ibuf_ready       (ibuf_ready),
        .ibuf_input_size  (ibuf_input_size),
        .pc               (pc),
        .inst             (inst),
        .have_exception   (have_exception),
        .exception_type   (exception_type),
        .branch_mistaken  (branch_mistaken),
        .correct_target   (correct_target),
        .rewind           (rewind),
        .rewind_target    (rewind_target),
        .raise_exception  (raise_exception),
        .exception_target (exception_target),
        .mmu_i            (mmu_i)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_pkts   (perf_fetch_pkts),
        .perf_killed_resps (perf_killed_resps),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present the MMU response for this cycle, then accept any request.
    task automatic prep();
        logic [31:0] base;
        if (resp_en && pend.size() > 0) begin
            base = pend[0] & ~32'h7;
            mmu_i.data_ok = 1'b1;
            for (int i = 0; i < FW; i++) mmu_i.rdata[i] = (base + 32'(4 * i)) ^ KEY;
        end else begin
            mmu_i.data_ok = 1'b0;
            mmu_i.rdata   = '0;
        end
        #1;
        mmu_i.addr_ok = mmu_i.valid;
        #1;
    endtask

    task automatic tick();
        logic        acc;
        logic        dok;
        logic        rst;
        logic [31:0] a;
        acc = mmu_i.valid & mmu_i.addr_ok;
        dok = mmu_i.data_ok;
        rst = reset;
        a   = mmu_i.addr;
        @(posedge clk);
        if (rst) begin
            pend.delete();
        end else begin
            if (dok) void'(pend.pop_front());
            if (acc) pend.push_back(a);
        end
        #2;
        branch_mistaken = 1'b0;
        rewind          = 1'b0;
        raise_exception = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prep();
        tick();
        prep();
        check("rst_valid", 32'(mmu_i.valid), 32'd0);
        check("rst_size", 32'(ibuf_input_size), 32'd0);
        check("rst_exc", 32'(have_exception), 32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ibuf_ready       = 1'b1;
        resp_en          = 1'b1;
        branch_mistaken  = 1'b0;
        rewind           = 1'b0;
        raise_exception  = 1'b0;
        correct_target   = '0;
        rewind_target    = '0;
        exception_target = '0;
        mmu_i.addr_ok    = 1'b0;
        mmu_i.data_ok    = 1'b0;
        mmu_i.rdata      = '0;
        mmu_i.tlbr       = 1'b0;
        mmu_i.pif        = 1'b0;
        mmu_i.ppi        = 1'b0;

        // Streaming fetch from reset
        do_reset();
        prep();
        check("c1_valid", 32'(mmu_i.valid), 32'd1);
        check("c1_addr", mmu_i.addr, 32'h1c000000);
        check("c1_msize", 32'(mmu_i.size), 32'd2);
        check("c1_size", 32'(ibuf_input_size), 32'd0);
        tick();
        prep();
        check("c2_size", 32'(ibuf_input_size), 32'd2);
        check("c2_pc0", pc[0], 32'h1c000000);
        check("c2_pc1", pc[1], 32'h1c000004);
        check("c2_inst0", inst[0], 32'h46000000);
        check("c2_inst1", inst[1], 32'h46000004);
        check("c2_addr", mmu_i.addr, 32'h1c000008);
        tick();
        prep();
        check("c3_pc0", pc[0], 32'h1c000008);
        check("c3_pc1", pc[1], 32'h1c00000c);
        tick();

        // Redirect with two requests outstanding
        resp_en = 1'b0;
        prep();
        check("c4_addr", mmu_i.addr, 32'h1c000018);
        tick();
        prep();
        check("full_valid", 32'(mmu_i.valid), 32'd0);
        tick();
        branch_mistaken = 1'b1;
        correct_target  = 32'h1c000104;
        prep();
        check("redir_size", 32'(ibuf_input_size), 32'd0);
        tick();
        resp_en = 1'b1;
        prep();
        check("kill1_size", 32'(ibuf_input_size), 32'd0);
        check("kill1_valid", 32'(mmu_i.valid), 32'd1);
        check("kill1_addr", mmu_i.addr, 32'h1c000104);
        check("kill1_msize", 32'(mmu_i.size), 32'd1);
        tick();
        prep();
        check("kill2_size", 32'(ibuf_input_size), 32'd0);
        check("kill2_addr", mmu_i.addr, 32'h1c000108);
        tick();
        prep();
        check("tgt_size", 32'(ibuf_input_size), 32'd1);
        check("tgt_pc0", pc[0], 32'h1c000104);
        check("tgt_inst0", inst[0], 32'h46000104);
        tick();

        // Trap beats branch in the same cycle, with addr_ok and data_ok
        raise_exception  = 1'b1;
        exception_target = 32'h1c000800;
        branch_mistaken  = 1'b1;
        correct_target   = 32'h1c000200;
        prep();
        check("prio_size", 32'(ibuf_input_size), 32'd0);
        check("prio_acc", 32'(mmu_i.valid), 32'd1);
        tick();
        prep();
        check("prio_addr", mmu_i.addr, 32'h1c000800);
        check("prio_k1", 32'(ibuf_input_size), 32'd0);
        tick();
        prep();
        check("prio_k2", 32'(ibuf_input_size), 32'd0);
        tick();
        prep();
        check("prio_pc0", pc[0], 32'h1c000800);
        check("prio_psize", 32'(ibuf_input_size), 32'd2);
        check("prio_inst0", inst[0], 32'h46000800);
        tick();

        // TLBR withheld behind an in-flight packet, then halt, then misaligned redirect
        do_reset();
        prep();
        tick();
        prep();
        check("t4_pkt0", pc[0], 32'h1c000000);
        tick();
        resp_en    = 1'b0;
        mmu_i.tlbr = 1'b1;
        prep();
        check("tlbr_hold_valid", 32'(mmu_i.valid), 32'd0);
        check("tlbr_hold_exc", 32'(have_exception), 32'd0);
        tick();
        resp_en = 1'b1;
        prep();
        check("tlbr_drain_pc0", pc[0], 32'h1c000008);
        check("tlbr_drain_exc", 32'(have_exception), 32'd0);
        tick();
        prep();
        check("tlbr_exc", 32'(have_exception), 32'd1);
        check("tlbr_type", 32'(exception_type), 32'(EXC_TLBR));
        check("tlbr_pc0", pc[0], 32'h1c000010);
        check("tlbr_size", 32'(ibuf_input_size), 32'd1);
        tick();
        mmu_i.tlbr = 1'b0;
        prep();
        check("halt_valid", 32'(mmu_i.valid), 32'd0);
        check("halt_exc", 32'(have_exception), 32'd0);
        tick();
        branch_mistaken = 1'b1;
        correct_target  = 32'h1c000002;
        prep();
        check("adef_redir_size", 32'(ibuf_input_size), 32'd0);
        tick();
        prep();
        check("adef_valid", 32'(mmu_i.valid), 32'd0);
        check("adef_exc", 32'(have_exception), 32'd1);
        check("adef_type", 32'(exception_type), 32'(EXC_ADEF));
        check("adef_pc0", pc[0], 32'h1c000002);
        check("adef_size", 32'(ibuf_input_size), 32'd1);
        tick();

        // ibuf back-pressure: no issue, in-flight response still delivered
        do_reset();
        prep();
        tick();
        ibuf_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            prep();
            check("stall_valid", 32'(mmu_i.valid), 32'd0);
            if (c == 0) check("stall_pkt_size", 32'(ibuf_input_size), 32'd2);
            tick();
        end
        ibuf_ready = 1'b1;
        prep();
        check("resume_valid", 32'(mmu_i.valid), 32'd1);
        check("resume_addr", mmu_i.addr, 32'h1c000008);
`ifdef IFU_PERF_CNT_EN
        check("perf_stall", perf_stall_cycles, 32'd5);
        check("perf_pkts", perf_fetch_pkts, 32'd1);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
